// File: rtl/pio_mem_rd_arb.sv
// Read-port arbiter for the PIO block RAM application read port.
// Round-robin among NREQ requesters, with optional strict priority for requester 0.
// A tag FIFO records which requester issued each read, so that the in-order
// memory acks can be steered back to the right requester.
module pio_mem_rd_arb #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 20,
  parameter int DEPTH_NBITS = 10,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prio0_en,
  input  logic [NREQ-1:0]               req_rd,
  input  logic [NREQ*DEPTH_NBITS-1:0]   req_raddr,
  output logic [NREQ-1:0]               req_gnt,
  output logic [NREQ-1:0]               req_ack,
  output logic [WIDTH-1:0]              req_rdata,
  output logic                          app_mem_rd,
  output logic [DEPTH_NBITS-1:0]        app_mem_raddr,
  input  logic                          app_mem_ack,
  input  logic [WIDTH-1:0]              app_mem_rdata,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          err_unexp_ack
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]        ack_q, ack_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   rd_q, rd_d;
  logic [DEPTH_NBITS-1:0] raddr_q, raddr_d;
  logic                   err_q, err_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ID_W-1:0]        tag_mem_q [TAG_DEPTH];
  logic [ID_W-1:0]        tag_mem_d [TAG_DEPTH];

  logic [NREQ-1:0]        elig;
  logic                   pop;
  logic                   fifo_full;
  logic                   do_grant;
  logic                   prio_win;
  logic                   rr_found;
  logic [ID_W-1:0]        rr_win;
  logic [ID_W-1:0]        win;
  int                     rr_idx;

  // Arbitration: the requester granted this cycle is masked so a held
  // request is never granted twice; a pop this cycle frees a FIFO slot.
  always_comb begin
    elig      = req_rd & ~gnt_q;
    pop       = app_mem_ack && (count_q != '0);
    fifo_full = (count_q == CNT_W'(TAG_DEPTH)) && !pop;
    do_grant  = (elig != '0) && !fifo_full;
    rr_win    = '0;
    rr_found  = 1'b0;
    rr_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!rr_found && elig[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = ID_W'(rr_idx);
      end
    end
    prio_win = prio0_en && elig[0];
    win      = prio_win ? '0 : rr_win;
  end

  // Next-state: grant/issue path, tag FIFO push/pop, return steering, error flag.
  always_comb begin
    gnt_d     = '0;
    rd_d      = 1'b0;
    raddr_d   = raddr_q;
    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_mem_d = tag_mem_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;

    if (do_grant) begin
      gnt_d               = NREQ'(1) << win;
      rd_d                = 1'b1;
      raddr_d             = req_raddr[win*DEPTH_NBITS +: DEPTH_NBITS];
      tag_mem_d[wr_ptr_q] = win;
      wr_ptr_d            = wr_ptr_q + 1'b1;
      // Priority wins for requester 0 do not disturb the rotation.
      if (!prio_win) begin
        rr_ptr_d = win;
      end
    end

    if (pop) begin
      ack_d    = NREQ'(1) << tag_mem_q[rd_ptr_q];
      rdata_d  = app_mem_rdata;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (app_mem_ack && (count_q == '0)) begin
      err_d = 1'b1;
    end

    case ({do_grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset flushes the tag FIFO and restarts rotation at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      raddr_q  <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= ID_W'(NREQ - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      raddr_q   <= raddr_d;
      err_q     <= err_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_mem_q <= tag_mem_d;
    end
  end

  assign req_gnt       = gnt_q;
  assign req_ack       = ack_q;
  assign req_rdata     = rdata_q;
  assign app_mem_rd    = rd_q;
  assign app_mem_raddr = raddr_q;
  assign outstanding   = count_q;
  assign err_unexp_ack = err_q;

endmodule

// File: tb/tb_pio_mem_rd_arb.sv
// Bench for pio_mem_rd_arb: fixed-latency memory model, grant/ack scoreboard,
// a vector table of single reads and hand-written multi-cycle sequences.
module tb_pio_mem_rd_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 20;
  localparam int DW    = 10;
  localparam int TD    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 prio0_en;
  logic [NREQ-1:0]      req_rd;
  logic [NREQ*DW-1:0]   req_raddr;
  logic [NREQ-1:0]      req_gnt;
  logic [NREQ-1:0]      req_ack;
  logic [WIDTH-1:0]     req_rdata;
  logic                 app_mem_rd;
  logic [DW-1:0]        app_mem_raddr;
  logic                 app_mem_ack;
  logic [WIDTH-1:0]     app_mem_rdata;
  logic [2:0]           outstanding;
  logic                 err_unexp_ack;

  pio_mem_rd_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH_NBITS(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .prio0_en(prio0_en),
    .req_rd(req_rd), .req_raddr(req_raddr),
    .req_gnt(req_gnt), .req_ack(req_ack), .req_rdata(req_rdata),
    .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
    .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
    .outstanding(outstanding), .err_unexp_ack(err_unexp_ack)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [WIDTH-1:0] data; } ack_exp_t;
  typedef struct { logic [DW-1:0] addr; int due; } mem_req_t;
  typedef struct { int id; logic [DW-1:0] addr; logic [WIDTH-1:0] rdata; logic [NREQ-1:0] onehot; } vec_t;

  int        n_checks = 0;
  int        n_pass   = 0;
  int        cyc      = 0;
  int        gnt_exp[$];
  ack_exp_t  ack_exp[$];
  mem_req_t  mem_q[$];
  bit        hold      = 1'b0;
  bit        force_ack = 1'b0;
  logic [DW-1:0] addr_of [NREQ];
  vec_t      vecs [4];

  function automatic logic [WIDTH-1:0] mem_word(input logic [DW-1:0] a);
    if (a == 10'h05A) return 20'hABCDE;
    return {a, a} ^ 20'h5A5A5;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_addr(input int i, input logic [DW-1:0] a);
    addr_of[i] = a;
    req_raddr[i*DW +: DW] = a;
  endtask

  // One clock: scoreboard the registered outputs, then run the memory model.
  task automatic tick();
    int       id;
    ack_exp_t e;
    mem_req_t m;
    @(posedge clk);
    #1;
    cyc++;
    if (req_gnt !== '0) begin
      if (gnt_exp.size() == 0) begin
        check_eq("unexpected_grant", 32'(req_gnt), 32'h0);
      end else begin
        id = gnt_exp.pop_front();
        check_eq("grant_id", 32'(req_gnt), 32'(1 << id));
        check_eq("grant_rd", 32'(app_mem_rd), 32'h1);
        check_eq("grant_addr", 32'(app_mem_raddr), 32'(addr_of[id]));
        ack_exp.push_back('{id: id, data: mem_word(addr_of[id])});
      end
    end else if (app_mem_rd !== 1'b0) begin
      check_eq("rd_without_grant", 32'(app_mem_rd), 32'h0);
    end
    if (req_ack !== '0) begin
      if (ack_exp.size() == 0) begin
        check_eq("unexpected_ack", 32'(req_ack), 32'h0);
      end else begin
        e = ack_exp.pop_front();
        check_eq("ack_id", 32'(req_ack), 32'(1 << e.id));
        check_eq("ack_data", 32'(req_rdata), 32'(e.data));
      end
    end
    if (app_mem_rd === 1'b1) mem_q.push_back('{addr: app_mem_raddr, due: cyc + 3});
    app_mem_ack   = 1'b0;
    app_mem_rdata = '0;
    if (force_ack) begin
      app_mem_ack   = 1'b1;
      app_mem_rdata = 20'h12345;
      force_ack     = 1'b0;
    end else if (!hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      app_mem_ack   = 1'b1;
      app_mem_rdata = mem_word(m.addr);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mem_q.size() != 0 || ack_exp.size() != 0 || app_mem_ack) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check_eq("drain_timeout", 32'(n), 32'h0);
    tick();
    check_eq("pending_grants_left", 32'(gnt_exp.size()), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ack_exp.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; prio0_en = 1'b0; req_rd = '0; req_raddr = '0;
    app_mem_ack = 1'b0; app_mem_rdata = '0;
    for (int i = 0; i < NREQ; i++) set_addr(i, DW'(10'h100 + 10'(i * 17)));

    vecs[0] = '{2, 10'h05A, 20'hABCDE, 4'b0100};
    vecs[1] = '{0, 10'h3FF, 20'hA5A5A, 4'b0001};
    vecs[2] = '{3, 10'h000, 20'h5A5A5, 4'b1000};
    vecs[3] = '{1, 10'h155, 20'h0F0F0, 4'b0010};

    #2;
    check_eq("rst_gnt", 32'(req_gnt), 32'h0);
    check_eq("rst_ack", 32'(req_ack), 32'h0);
    check_eq("rst_rdata", 32'(req_rdata), 32'h0);
    check_eq("rst_rd", 32'(app_mem_rd), 32'h0);
    check_eq("rst_raddr", 32'(app_mem_raddr), 32'h0);
    check_eq("rst_outstanding", 32'(outstanding), 32'h0);
    check_eq("rst_err", 32'(err_unexp_ack), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single reads: exact T+1 grant and T+5 data latency.
    for (int v = 0; v < 4; v++) begin
      set_addr(vecs[v].id, vecs[v].addr);
      req_rd[vecs[v].id] = 1'b1;
      gnt_exp.push_back(vecs[v].id);
      tick();
      check_eq("single_gnt", 32'(req_gnt), 32'(vecs[v].onehot));
      check_eq("single_raddr", 32'(app_mem_raddr), 32'(vecs[v].addr));
      req_rd = '0;
      tick(); tick(); tick();
      check_eq("single_ack_early", 32'(req_ack), 32'h0);
      tick();
      check_eq("single_ack", 32'(req_ack), 32'(vecs[v].onehot));
      check_eq("single_rdata", 32'(req_rdata), 32'(vecs[v].rdata));
      drain();
    end

    // Round-robin, all four held: 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_addr(i, DW'(10'h200 + 10'(i * 3)));
    for (int r = 0; r < 2; r++) for (int i = 0; i < NREQ; i++) gnt_exp.push_back(i);
    req_rd = 4'b1111;
    for (int k = 0; k < 8; k++) tick();
    req_rd = '0;
    drain();

    // Priority 0 with requesters 0,1,3: 0,1,0,3,0,1.
    do_reset();
    prio0_en = 1'b1;
    gnt_exp = '{0, 1, 0, 3, 0, 1};
    req_rd = 4'b1011;
    for (int k = 0; k < 6; k++) tick();
    req_rd = '0;
    prio0_en = 1'b0;
    drain();

    // FIFO full: acks held off, four grants then requester 0 stays pending.
    do_reset();
    hold = 1'b1;
    gnt_exp = '{0, 1, 2, 3};
    req_rd = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      for (int i = 1; i < NREQ; i++) if (req_gnt[i]) req_rd[i] = 1'b0;
    end
    check_eq("full_outstanding", 32'(outstanding), 32'd4);
    check_eq("full_no_grant", 32'(req_gnt), 32'h0);
    gnt_exp.push_back(0);
    hold = 1'b0;
    tick();
    check_eq("full_pop_cycle_gnt", 32'(req_gnt), 32'h0);
    check_eq("full_pop_cycle_out", 32'(outstanding), 32'd4);
    tick();
    check_eq("full_regrant", 32'(req_gnt), 32'b0001);
    check_eq("full_push_pop_out", 32'(outstanding), 32'd4);
    req_rd = '0;
    drain();
    check_eq("full_drained_out", 32'(outstanding), 32'd0);

    // Unexpected ack is sticky until reset.
    check_eq("err_before", 32'(err_unexp_ack), 32'h0);
    force_ack = 1'b1;
    tick();
    tick();
    check_eq("err_set", 32'(err_unexp_ack), 32'h1);
    tick(); tick(); tick();
    check_eq("err_sticky", 32'(err_unexp_ack), 32'h1);
    check_eq("err_outstanding", 32'(outstanding), 32'h0);
    do_reset();
    check_eq("err_cleared", 32'(err_unexp_ack), 32'h0);

    // Reset with two reads in flight.
    for (int i = 0; i < NREQ; i++) set_addr(i, DW'(10'h080 + 10'(i)));
    gnt_exp = '{0, 1};
    req_rd = 4'b0011;
    tick();
    req_rd[0] = 1'b0;
    tick();
    req_rd[1] = 1'b0;
    check_eq("mid_outstanding", 32'(outstanding), 32'd2);
    rst = 1'b1;
    ack_exp.delete();
    #1;
    check_eq("mid_rst_gnt", 32'(req_gnt), 32'h0);
    check_eq("mid_rst_rd", 32'(app_mem_rd), 32'h0);
    check_eq("mid_rst_raddr", 32'(app_mem_raddr), 32'h0);
    check_eq("mid_rst_outstanding", 32'(outstanding), 32'h0);
    tick();
    rst = 1'b0;
    drain();
    check_eq("stale_ack_err", 32'(err_unexp_ack), 32'h1);
    gnt_exp.push_back(0);
    req_rd = 4'b1011;
    tick();
    check_eq("post_rst_first_gnt", 32'(req_gnt), 32'b0001);
    req_rd = '0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/pio_mem_rd_arb.md
# pio_mem_rd_arb

Read-port arbiter for a PIO-accessible block RAM. It shares the single application read port (app_mem_rd / app_mem_raddr / app_mem_ack / app_mem_rdata) among NREQ application requesters. Arbitration is round-robin, with optional strict priority for requester 0. The block tracks in-flight reads in a tag FIFO and steers each returned word to the requester that issued it. It sits between application engines and the PIO memory wrapper, whose read ack arrives a fixed 3 cycles after app_mem_rd.

## Interface

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 20, memory word width
- DEPTH_NBITS, 10, memory address width
- TAG_DEPTH, 4, in-flight tag FIFO entries (power of 2, ≥ 4)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high; declared with the team reset macros
- prio0_en  in  1  requester 0 wins over round-robin when requesting
- req_rd  in  NREQ  per-requester read request; level, held until granted
- req_raddr  in  NREQ*DEPTH_NBITS  packed addresses; requester i at bits [i*DEPTH_NBITS +: DEPTH_NBITS]
- req_gnt  out  NREQ  one-hot, one-cycle grant pulse
- req_ack  out  NREQ  one-hot, one-cycle read-data-valid
- req_rdata  out  WIDTH  read data, valid with req_ack
- app_mem_rd  out  1  read strobe to memory
- app_mem_raddr  out  DEPTH_NBITS  read address to memory
- app_mem_ack  in  1  memory read ack (3 cycles after app_mem_rd)
- app_mem_rdata  in  WIDTH  memory read data, valid with app_mem_ack
- outstanding  out  log2(TAG_DEPTH)+1  reads issued but not yet acked
- err_unexp_ack  out  1  sticky: app_mem_ack arrived while the tag FIFO was empty

## Operation

- Eligible set: req_rd & ~req_gnt. A requester being granted this cycle is excluded, so a held request is never double-granted.
- Grant condition: eligible set non-empty and tag FIFO not full, with a pop in the same cycle counting as freeing a slot.
- Winner selection:
  - if prio0_en and requester 0 is eligible, requester 0 wins;
  - otherwise, first eligible index searching upward from rr_ptr+1 modulo NREQ.
- rr_ptr updates to the winner only on round-robin wins. Priority-0 wins leave rr_ptr unchanged. Reset value of rr_ptr is NREQ-1, so requester 0 is first.
- On a win, the following are all registered, asserted the next cycle, and in the same cycle:
  - req_gnt[w] = 1
  - app_mem_rd = 1
  - app_mem_raddr = req_raddr of w, sampled in the decision cycle
  - tag FIFO push of w
- Requester rule: deassert req_rd or present a new address in the cycle after seeing req_gnt.
- Return path, on app_mem_ack:
  - pop the FIFO head id h;
  - next cycle, req_ack[h] = 1 and req_rdata = app_mem_rdata (registered).
- Returns are in order; the FIFO needs no reordering.
- Unexpected ack: app_mem_ack with the FIFO empty sets err_unexp_ack (cleared only by reset). No pop, no req_ack.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- outstanding equals the FIFO count.

## Timing

- Reset values: req_gnt = 0, req_ack = 0, req_rdata = 0, app_mem_rd = 0, app_mem_raddr = 0, outstanding = 0, err_unexp_ack = 0. FIFO pointers and rr_ptr are also reset.
- Latency, request to data:
  - req_rd sampled at T;
  - req_gnt and app_mem_rd at T+1;
  - app_mem_ack at T+4;
  - req_ack at T+5.
- Throughput: one grant per cycle, across different requesters. A single requester with req_rd held continuously is granted every other cycle, because it is masked in its own grant cycle.
- FIFO full (count = TAG_DEPTH with no pop in that cycle): no grant. Requests stay pending, with no loss and no reordering.
- Reset mid-operation: the FIFO is flushed and outstanding returns to 0 immediately. Memory acks still in flight after reset deassertion set err_unexp_ack. Software treats the error as expected after a warm reset.
- rdata width: passes through unchanged. No truncation and no extension.

## Test plan

- Single read: req_rd[2] = 1 with addr 0x05A at T.
  - Expect req_gnt = 4'b0100 and app_mem_raddr = 0x05A at T+1.
  - Model ack at T+4 with rdata 0xABCDE.
  - Expect req_ack = 4'b0100 and req_rdata = 0xABCDE at T+5.
- Round-robin: all four requesters hold req_rd, prio0_en = 0.
  - Grants cycle 0, 1, 2, 3, 0, … one per cycle.
  - req_ack order matches grant order.
- Priority: prio0_en = 1 with requesters 0, 1 and 3 held.
  - Grants are 0, 1, 0, 3, 0, 1, …
  - Requester 0 is masked in its own grant cycle, so the others fit in between.
  - rr_ptr is unaffected by the 0-wins.
- FIFO full: hold the memory-model ack off while four grants issue.
  - outstanding = 4 and no fifth grant.
  - Release one ack: the next grant occurs the cycle after the pop is seen, with no request lost.
- Unexpected ack: pulse app_mem_ack with outstanding = 0.
  - err_unexp_ack = 1 and stays 1; no req_ack.
  - Only rst clears it.
- Reset mid-flight: assert rst with 2 reads outstanding.
  - All outputs go to 0 immediately and outstanding = 0.
  - The first grant after reset goes to requester 0.
